// File: rtl/uart_tx_arbiter_pkg.sv
// Shared uart settings and arbiter state encoding.
package uart_tx_arbiter_pkg;

    localparam int unsigned UART_DBIT    = 8;
    localparam int unsigned UART_TIMEOUT = 1024;

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter.sv
// Two-requester, message-granular round-robin arbiter feeding a uart TX FIFO.
// A grant is held until the owner's last byte transfers or the owner sits
// idle (valid low) for TIMEOUT cycles; FIFO back-pressure never counts as idle.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned DBIT    = UART_DBIT,
    parameter int unsigned TIMEOUT = UART_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    input  logic [DBIT-1:0] req_data0,
    input  logic [DBIT-1:0] req_data1,
    input  logic [1:0]      req_last,
    output logic [1:0]      req_ready,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    output logic [1:0]      grant,
    output logic            abort_tick
);

    localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

    arb_state_e  state_q, state_d;
    logic        rr_q, rr_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        abort_q, abort_d;

    // State, round-robin pointer, idle counter and abort pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            idle_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            idle_cnt_q <= idle_cnt_d;
            abort_q    <= abort_d;
        end
    end

    // Arbitration, zero-latency byte pass-through and timeout handling.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        idle_cnt_d = idle_cnt_q;
        abort_d    = 1'b0;
        req_ready  = '0;
        wr_uart    = 1'b0;
        w_data     = req_data0;

        unique case (state_q)
            IDLE: begin
                idle_cnt_d = '0;
                unique case (req_valid)
                    2'b01:   state_d = GNT0;
                    2'b10:   state_d = GNT1;
                    2'b11:   state_d = rr_q ? GNT1 : GNT0;
                    default: state_d = IDLE;
                endcase
            end
            GNT0: begin
                req_ready = {1'b0, ~tx_full};
                wr_uart   = req_valid[0] & ~tx_full;
                w_data    = req_data0;
                if (req_valid[0]) begin
                    idle_cnt_d = '0;
                    if (!tx_full && req_last[0]) begin
                        state_d = IDLE;
                        rr_d    = 1'b1;
                    end
                end else if (idle_cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    rr_d    = 1'b1;
                    abort_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
            GNT1: begin
                req_ready = {~tx_full, 1'b0};
                wr_uart   = req_valid[1] & ~tx_full;
                w_data    = req_data1;
                if (req_valid[1]) begin
                    idle_cnt_d = '0;
                    if (!tx_full && req_last[1]) begin
                        state_d = IDLE;
                        rr_d    = 1'b0;
                    end
                end else if (idle_cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    rr_d    = 1'b0;
                    abort_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant      = state_q;
    assign abort_tick = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (TIMEOUT overridden to 4).
module tb_uart_tx_arbiter;

    localparam int unsigned DBIT = 8;

    logic            clk;
    logic            reset;
    logic [1:0]      req_valid;
    logic [DBIT-1:0] req_data0;
    logic [DBIT-1:0] req_data1;
    logic [1:0]      req_last;
    logic [1:0]      req_ready;
    logic            tx_full;
    logic            wr_uart;
    logic [DBIT-1:0] w_data;
    logic [1:0]      grant;
    logic            abort_tick;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    uart_tx_arbiter #(
        .DBIT    (DBIT),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_full    (tx_full),
        .wr_uart    (wr_uart),
        .w_data     (w_data),
        .grant      (grant),
        .abort_tick (abort_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are already driven for this cycle; check outputs mid-cycle, then
    // advance to 1 time unit past the next rising edge.
    task automatic cyc(input string tag, input logic [1:0] g, input logic [1:0] rdy,
                       input logic wr, input logic [7:0] wd, input logic ab);
        #2;
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".ready"}, 32'(req_ready), 32'(rdy));
        check({tag, ".wr"}, 32'(wr_uart), 32'(wr));
        if (wr) check({tag, ".wdata"}, 32'(w_data), 32'(wd));
        check({tag, ".abort"}, 32'(abort_tick), 32'(ab));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data0 = '0;
        req_data1 = '0;
        req_last  = '0;
        tx_full   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        // Reset state.
        cyc("rst", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;

        // Three-byte message from requester 0.
        req_valid = 2'b01; req_data0 = 8'h41; req_last = 2'b00;
        cyc("a.arb", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        cyc("a.b0", 2'b01, 2'b01, 1'b1, 8'h41, 1'b0);
        req_data0 = 8'h42;
        cyc("a.b1", 2'b01, 2'b01, 1'b1, 8'h42, 1'b0);
        req_data0 = 8'h43; req_last = 2'b01;
        cyc("a.b2", 2'b01, 2'b01, 1'b1, 8'h43, 1'b0);
        // Both now pending: rr points at requester 1.
        req_valid = 2'b11; req_data0 = 8'h10; req_data1 = 8'h20; req_last = 2'b10;
        cyc("a.idle", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        cyc("a.rr1", 2'b10, 2'b10, 1'b1, 8'h20, 1'b0);
        req_valid = 2'b00; req_last = 2'b00;
        cyc("a.end", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);

        // Reset, then both requesters with 2-byte messages.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 2'b11; req_data0 = 8'hA0; req_data1 = 8'hB0; req_last = 2'b00;
        cyc("b.arb0", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        cyc("b.r0b0", 2'b01, 2'b01, 1'b1, 8'hA0, 1'b0);
        req_data0 = 8'hA1; req_last = 2'b01;
        cyc("b.r0b1", 2'b01, 2'b01, 1'b1, 8'hA1, 1'b0);
        req_data0 = 8'hC0; req_last = 2'b00;
        cyc("b.arb1", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        cyc("b.r1b0", 2'b10, 2'b10, 1'b1, 8'hB0, 1'b0);
        req_data1 = 8'hB1; req_last = 2'b10;
        cyc("b.r1b1", 2'b10, 2'b10, 1'b1, 8'hB1, 1'b0);
        req_data1 = 8'hD0; req_last = 2'b00;
        cyc("b.arb2", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        cyc("b.r0c0", 2'b01, 2'b01, 1'b1, 8'hC0, 1'b0);
        req_data0 = 8'hC1; req_last = 2'b01;
        cyc("b.r0c1", 2'b01, 2'b01, 1'b1, 8'hC1, 1'b0);
        req_valid = 2'b00; req_last = 2'b00;
        cyc("b.end", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);

        // tx_full stall longer than TIMEOUT must not abort.
        req_valid = 2'b01; req_data0 = 8'h55; req_last = 2'b01;
        cyc("c.arb", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        tx_full = 1'b1;
        for (int i = 0; i < 5; i++)
            cyc("c.stall", 2'b01, 2'b00, 1'b0, 8'h00, 1'b0);
        tx_full = 1'b0;
        cyc("c.xfer", 2'b01, 2'b01, 1'b1, 8'h55, 1'b0);
        req_valid = 2'b00; req_last = 2'b00;
        cyc("c.end", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);

        // Timeout abort on requester 1 (rr currently 1 after requester 0).
        req_valid = 2'b10; req_data1 = 8'h77; req_last = 2'b00;
        cyc("d.arb", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        cyc("d.b0", 2'b10, 2'b10, 1'b1, 8'h77, 1'b0);
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++)
            cyc("d.wait", 2'b10, 2'b10, 1'b0, 8'h00, 1'b0);
        req_valid = 2'b11; req_data0 = 8'h01; req_data1 = 8'h02; req_last = 2'b11;
        cyc("d.abort", 2'b00, 2'b00, 1'b0, 8'h00, 1'b1);
        cyc("d.rr0", 2'b01, 2'b01, 1'b1, 8'h01, 1'b0);
        req_valid = 2'b00; req_last = 2'b00;
        cyc("d.end", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);

        // Reset during byte 2 of a 4-byte message.
        req_valid = 2'b01; req_data0 = 8'h61; req_last = 2'b00;
        cyc("e.arb", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        cyc("e.b0", 2'b01, 2'b01, 1'b1, 8'h61, 1'b0);
        req_data0 = 8'h62;
        reset = 1'b1;
        cyc("e.b1", 2'b01, 2'b01, 1'b1, 8'h62, 1'b0);
        cyc("e.rst0", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        cyc("e.rst1", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        reset = 1'b0; req_valid = 2'b00;
        cyc("e.post0", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
        cyc("e.post1", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);

        // Alternating single-byte messages, 2 cycles each, rr starts at 0.
        req_valid = 2'b11; req_data0 = 8'hE0; req_data1 = 8'hF0; req_last = 2'b11;
        for (int i = 0; i < 4; i++) begin
            cyc("f.arb", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
            if (i % 2 == 0)
                cyc("f.g0", 2'b01, 2'b01, 1'b1, 8'hE0, 1'b0);
            else
                cyc("f.g1", 2'b10, 2'b10, 1'b1, 8'hF0, 1'b0);
        end
        req_valid = 2'b00; req_last = 2'b00;
        cyc("f.end", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
